mux_reg_n: RTL and testbench

- Parametrised N-way, W-bit selector with a registered output and a valid/ready handshake on both sides.
- Successor to the fixed 5-input 32-bit combinational datapath mux.
- Sits between datapath producers and consumers that may stall, e.g. the write-back select feeding a stallable register-file port.
- A one-entry skid buffer keeps full throughput. Out-of-range selects are dropped and flagged instead of latching stale data.

---
 rtl/mux_reg_n_pkg.sv | 11 +
 rtl/mux_reg_n_sel_n_comb.sv | 27 ++
 rtl/mux_reg_n.sv | 132 +++++++++++++
 tb/tb_mux_reg_n.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_reg_n_pkg.sv
// Shared definitions for the registered N-way selector.
// State encoding is {valido_out, skid_valid}.
package mux_reg_n_pkg;

    localparam int LARGURA_PADRAO = 32;

    localparam logic [1:0] ESTADO_VAZIO = 2'b00;
    localparam logic [1:0] ESTADO_CHEIO = 2'b10;
    localparam logic [1:0] ESTADO_SKID  = 2'b11;

endpackage

// File: rtl/mux_reg_n_sel_n_comb.sv
// Pure combinational N-way word selector.
// fora_faixa flags a select beyond the last input.
module sel_n_comb
    import mux_reg_n_pkg::*;
#(
    parameter int LARGURA    = LARGURA_PADRAO,
    parameter int N_ENTRADAS = 5,
    parameter int SEL_W      = $clog2(N_ENTRADAS)
) (
    input  logic [N_ENTRADAS*LARGURA-1:0] entradas,
    input  logic [SEL_W-1:0]              sel,
    output logic [LARGURA-1:0]            dado,
    output logic                          fora_faixa
);

    always_comb begin
        dado = '0;
        for (int i = 0; i < N_ENTRADAS; i++) begin
            if (sel == SEL_W'(i)) begin
                dado = entradas[i*LARGURA +: LARGURA];
            end
        end
    end

    assign fora_faixa = (32'(sel) >= N_ENTRADAS);

endmodule

// File: rtl/mux_reg_n.sv
// Registered N-way selector with valid/ready on both sides.
// A one-entry skid buffer keeps throughput under stall.
module mux_reg_n
    import mux_reg_n_pkg::*;
#(
    parameter int LARGURA    = LARGURA_PADRAO,
    parameter int N_ENTRADAS = 5,
    parameter int CNT_W      = 8,
    localparam int SEL_W     = $clog2(N_ENTRADAS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_ENTRADAS*LARGURA-1:0] entradas,
    input  logic [SEL_W-1:0]              controle,
    input  logic                          valido_in,
    output logic                          pronto_out,
    output logic [LARGURA-1:0]            saida,
    output logic                          valido_out,
    input  logic                          pronto_in,
    output logic                          erro_sel,
    input  logic                          limpa_erro,
    output logic [CNT_W-1:0]              cnt_descarte
);

    localparam bit POT2 = ((N_ENTRADAS & (N_ENTRADAS - 1)) == 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LARGURA-1:0] saida_q, saida_d;
    logic [LARGURA-1:0] skid_q, skid_d;
    logic               vo_q, vo_d;
    logic               sv_q, sv_d;
    logic               erro_q, erro_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_base;

    logic [LARGURA-1:0] sel_dado;
    logic               fora;
    logic               aceita, legal, ilegal, drena;
    logic [1:0]         estado;

    sel_n_comb #(
        .LARGURA   (LARGURA),
        .N_ENTRADAS(N_ENTRADAS),
        .SEL_W     (SEL_W)
    ) u_sel (
        .entradas  (entradas),
        .sel       (controle),
        .dado      (sel_dado),
        .fora_faixa(fora)
    );

    assign estado = {vo_q, sv_q};
    assign aceita = valido_in & ~sv_q;
    assign legal  = aceita & ~fora;
    assign ilegal = aceita & fora;
    assign drena  = vo_q & pronto_in;

    always_comb begin
        saida_d = saida_q;
        skid_d  = skid_q;
        vo_d    = vo_q;
        sv_d    = sv_q;
        case (estado)
            ESTADO_VAZIO: begin
                if (legal) begin
                    saida_d = sel_dado;
                    vo_d    = 1'b1;
                end
            end
            ESTADO_CHEIO: begin
                if (drena && legal) begin
                    saida_d = sel_dado;
                end else if (drena) begin
                    vo_d = 1'b0;
                end else if (legal) begin
                    skid_d = sel_dado;
                    sv_d   = 1'b1;
                end
            end
            ESTADO_SKID: begin
                if (drena) begin
                    saida_d = skid_q;
                    sv_d    = 1'b0;
                end
            end
            default: begin
                // Orphaned skid entry: promote it to the output.
                saida_d = skid_q;
                vo_d    = 1'b1;
                sv_d    = 1'b0;
            end
        endcase
    end

    // An illegal beat in the same cycle as a clear counts from zero.
    always_comb begin
        cnt_base = limpa_erro ? '0 : cnt_q;
        erro_d   = limpa_erro ? 1'b0 : erro_q;
        cnt_d    = cnt_base;
        if (ilegal) begin
            erro_d = 1'b1;
            if (cnt_base != CNT_MAX) begin
                cnt_d = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saida_q <= '0;
            skid_q  <= '0;
            vo_q    <= 1'b0;
            sv_q    <= 1'b0;
            erro_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            saida_q <= saida_d;
            skid_q  <= skid_d;
            vo_q    <= vo_d;
            sv_q    <= sv_d;
            erro_q  <= erro_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pronto_out   = ~sv_q;
    assign saida        = saida_q;
    assign valido_out   = vo_q;
    assign erro_sel     = POT2 ? 1'b0 : erro_q;
    assign cnt_descarte = POT2 ? '0 : cnt_q;

endmodule

// File: tb/tb_mux_reg_n.sv
// Scoreboard bench for mux_reg_n: directed vectors, queue-based checking.
module tb_mux_reg_n;

    localparam int W = 32;
    localparam int N = 5;
    localparam int SW = 3;

    logic          clock;
    logic          reset;
    logic [N*W-1:0] entradas;
    logic [SW-1:0] controle;
    logic          valido_in;
    logic          pronto_out;
    logic [W-1:0]  saida;
    logic          valido_out;
    logic          pronto_in;
    logic          erro_sel;
    logic          limpa_erro;
    logic [7:0]    cnt_descarte;

    logic [SW-1:0] controle_s;
    logic          valido_in_s;
    logic          pronto_out_s;
    logic [W-1:0]  saida_s;
    logic          valido_out_s;
    logic          erro_sel_s;
    logic [1:0]    cnt_s;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    mux_reg_n #(.LARGURA(W), .N_ENTRADAS(N), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .entradas(entradas),
        .controle(controle), .valido_in(valido_in),
        .pronto_out(pronto_out), .saida(saida),
        .valido_out(valido_out), .pronto_in(pronto_in),
        .erro_sel(erro_sel), .limpa_erro(limpa_erro),
        .cnt_descarte(cnt_descarte)
    );

    mux_reg_n #(.LARGURA(W), .N_ENTRADAS(N), .CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .entradas(entradas),
        .controle(controle_s), .valido_in(valido_in_s),
        .pronto_out(pronto_out_s), .saida(saida_s),
        .valido_out(valido_out_s), .pronto_in(1'b1),
        .erro_sel(erro_sel_s), .limpa_erro(1'b0),
        .cnt_descarte(cnt_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string nome, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nome, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset && valido_in && pronto_out && controle < SW'(N)) begin
            exp_q.push_back(32'hA000_0000 + 32'(controle));
        end
    end

    always @(negedge clock) begin
        if (reset && valido_out && pronto_in) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got %h want none", saida);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (saida !== e) begin
                    bad++;
                    $display("FAIL sb_data: got %h want %h", saida, e);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            entradas[i*W +: W] = 32'hA000_0000 + 32'(i);
        end
        reset = 1'b0;
        controle = '0;
        valido_in = 1'b0;
        pronto_in = 1'b1;
        limpa_erro = 1'b0;
        controle_s = '0;
        valido_in_s = 1'b0;
        #12;
        check("rst_saida", saida, 0);
        check("rst_vo", 32'(valido_out), 0);
        check("rst_erro", 32'(erro_sel), 0);
        check("rst_cnt", 32'(cnt_descarte), 0);
        step();
        reset = 1'b1;
        step();
        check("rst_pronto", 32'(pronto_out), 1);

        controle = 3'd3;
        valido_in = 1'b1;
        step();
        valido_in = 1'b0;
        check("one_vo", 32'(valido_out), 1);
        check("one_data", saida, 32'hA000_0003);
        step();
        check("one_vo_off", 32'(valido_out), 0);

        pronto_in = 1'b0;
        controle = 3'd1;
        valido_in = 1'b1;
        step();
        check("bp_pronto1", 32'(pronto_out), 1);
        controle = 3'd4;
        step();
        valido_in = 1'b0;
        check("bp_pronto0", 32'(pronto_out), 0);
        check("bp_saida", saida, 32'hA000_0001);
        step();
        check("bp_stable", saida, 32'hA000_0001);
        pronto_in = 1'b1;
        step();
        check("bp_second", saida, 32'hA000_0004);
        check("bp_pronto_back", 32'(pronto_out), 1);
        step();
        check("bp_empty", 32'(valido_out), 0);
        check("bp_q", 32'(exp_q.size()), 0);

        controle = 3'd6;
        valido_in = 1'b1;
        repeat (3) step();
        valido_in = 1'b0;
        check("ill_vo", 32'(valido_out), 0);
        check("ill_erro", 32'(erro_sel), 1);
        check("ill_cnt", 32'(cnt_descarte), 3);

        valido_in = 1'b1;
        limpa_erro = 1'b1;
        step();
        valido_in = 1'b0;
        check("clr_ill_erro", 32'(erro_sel), 1);
        check("clr_ill_cnt", 32'(cnt_descarte), 1);
        step();
        limpa_erro = 1'b0;
        check("clr_erro", 32'(erro_sel), 0);
        check("clr_cnt", 32'(cnt_descarte), 0);

        controle_s = 3'd5;
        valido_in_s = 1'b1;
        repeat (2) step();
        check("sat_mid", 32'(cnt_s), 2);
        repeat (4) step();
        valido_in_s = 1'b0;
        check("sat_cnt", 32'(cnt_s), 3);
        check("sat_erro", 32'(erro_sel_s), 1);
        check("sat_vo", 32'(valido_out_s), 0);

        valido_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            controle = SW'(k % N);
            step();
            check("str_vo", 32'(valido_out), 1);
            check("str_pronto", 32'(pronto_out), 1);
            check("str_data", saida, 32'hA000_0000 + 32'(k % N));
        end
        valido_in = 1'b0;
        step();
        check("str_end", 32'(valido_out), 0);

        pronto_in = 1'b0;
        controle = 3'd2;
        valido_in = 1'b1;
        step();
        controle = 3'd0;
        step();
        valido_in = 1'b0;
        check("skid_pronto", 32'(pronto_out), 0);
        reset = 1'b0;
        #2;
        check("arst_vo", 32'(valido_out), 0);
        check("arst_pronto", 32'(pronto_out), 1);
        check("arst_saida", saida, 0);
        exp_q.delete();
        step();
        reset = 1'b1;
        pronto_in = 1'b1;
        step();
        check("arst_after", 32'(valido_out), 0);
        check("final_q", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
